// File: rtl/bj_pkg.sv
// bj_pkg: shared constants for the blackjack front end (debounce FSM states, debounce lengths, key indices)
package bj_pkg;
   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } deb_state_t;
   localparam int DEBOUNCE_SIM   = 4;
   localparam int DEBOUNCE_BOARD = 500000;
   localparam int KEY_HIT        = 0;
   localparam int KEY_STAND      = 1;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: one key's 2-flop synchronizer, debounce FSM and registered level/press/release outputs
module key_debounce
   import bj_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_n,
   output logic o_level,
   output logic o_press,
   output logic o_release
);
   localparam logic [CNT_W-1:0] DC = CNT_W'(DEBOUNCE_CYCLES);
   logic [1:0]       r_sync;
   deb_state_t       r_state;
   deb_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_level;
   logic             r_press;
   logic             r_release;
   logic             w_s;
   logic             w_press;
   logic             w_release;
   assign w_s = ~r_sync[1];
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_press     = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         RELEASED: begin
            w_state_nxt = w_s ? PRESS_WAIT : RELEASED;
            w_cnt_nxt   = w_s ? CNT_W'(1) : '0;
         end
         PRESS_WAIT: begin
            if (!w_s) begin
               w_state_nxt = RELEASED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == DC) begin
               w_state_nxt = PRESSED;
               w_cnt_nxt   = '0;
               w_press     = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         PRESSED: begin
            w_state_nxt = w_s ? PRESSED : RELEASE_WAIT;
            w_cnt_nxt   = w_s ? '0 : CNT_W'(1);
         end
         default: begin
            if (w_s) begin
               w_state_nxt = PRESSED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == DC) begin
               w_state_nxt = RELEASED;
               w_cnt_nxt   = '0;
               w_release   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
      endcase
   end
   // outputs are derived from the next state so they change on the accepting edge
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync    <= 2'b11;
         r_state   <= RELEASED;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], i_key_n};
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_level   <= (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
         r_press   <= w_press;
         r_release <= w_release;
      end
   end
   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: turns raw active-low pushbuttons into debounced, synchronous level/press/release events
module key_conditioner
   import bj_pkg::*;
#(
   parameter int N_KEYS = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   input  logic [N_KEYS-1:0] key_n,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release
);
   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W(CNT_W)
      ) u_deb (
         .i_clk(CLOCK_50),
         .i_rst_n(resetn),
         .i_key_n(key_n[k]),
         .o_level(key_level[k]),
         .o_press(key_press[k]),
         .o_release(key_release[k])
      );
   end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: vector table, hand-written corner sequences and random stimulus against a sliding-window model
module tb_key_conditioner;
   import bj_pkg::*;
   localparam int DC = DEBOUNCE_SIM;
   typedef struct {
      logic [1:0] kn;
      int         n;
      logic [1:0] pm;
      logic [1:0] rm;
      int         at;
      logic [3:0] pr;
      logic [1:0] lvl;
   } seg_t;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [1:0] key_n = 2'b00;
   logic [1:0] key_level;
   logic [1:0] key_press;
   logic [1:0] key_release;
   int         checks = 0;
   int         errors = 0;
   logic [1:0] m1, m2, m_level, m_press, m_rel;
   logic [DC:0] win [2];
   seg_t       tbl [11];
   always #5 clk = ~clk;
   key_conditioner #(.N_KEYS(2), .DEBOUNCE_CYCLES(DC)) dut (
      .CLOCK_50(clk),
      .resetn(resetn),
      .key_n(key_n),
      .key_level(key_level),
      .key_press(key_press),
      .key_release(key_release)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      m1 = 2'b00;
      m2 = 2'b00;
      m_level = 2'b00;
      m_press = 2'b00;
      m_rel = 2'b00;
      win[0] = '0;
      win[1] = '0;
   endtask
   // a change is accepted once the last DC+1 synchronized samples all disagree with the held level
   task automatic model_edge(input logic [1:0] kn);
      logic [1:0] s;
      s = m2;
      m2 = m1;
      m1 = ~kn;
      for (int k = 0; k < 2; k++) begin
         win[k] = {win[k][DC-1:0], s[k]};
         m_press[k] = !m_level[k] && (&win[k]);
         m_rel[k] = m_level[k] && !(|win[k]);
         if (m_press[k]) m_level[k] = 1'b1;
         if (m_rel[k]) m_level[k] = 1'b0;
      end
   endtask
   task automatic step(input logic [1:0] kn, input logic rn);
      @(negedge clk);
      key_n = kn;
      resetn = rn;
      @(posedge clk);
      if (!rn) model_reset();
      else model_edge(kn);
      #1;
      chk("model_level", key_level, m_level);
      chk("model_press", key_press, m_press);
      chk("model_release", key_release, m_rel);
   endtask
   initial begin
      int pc [2];
      int rc [2];
      int first;
      logic [3:0] pr;
      int bp, lv, left;
      logic [1:0] kn;
      tbl = '{
         '{2'b11, 20, 2'b00, 2'b11, 7, 4'b0011, 2'b00},
         '{2'b11, 10, 2'b00, 2'b00, 0, 4'b0000, 2'b00},
         '{2'b10, 20, 2'b01, 2'b00, 7, 4'b0100, 2'b01},
         '{2'b11, 20, 2'b00, 2'b01, 7, 4'b0001, 2'b00},
         '{2'b10,  4, 2'b00, 2'b00, 0, 4'b0000, 2'b00},
         '{2'b11, 12, 2'b00, 2'b00, 0, 4'b0000, 2'b00},
         '{2'b10,  5, 2'b00, 2'b00, 0, 4'b0000, 2'b00},
         '{2'b11, 20, 2'b01, 2'b01, 2, 4'b0100, 2'b00},
         '{2'b00, 20, 2'b11, 2'b00, 7, 4'b1100, 2'b11},
         '{2'b01, 20, 2'b00, 2'b01, 7, 4'b0001, 2'b10},
         '{2'b11, 20, 2'b00, 2'b10, 7, 4'b0010, 2'b00}
      };
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step(2'b00, 1'b0);
         chk("reset_outputs", {key_level, key_press, key_release}, 6'd0);
      end
      for (int i = 1; i <= 8; i++) begin
         step(2'b00, 1'b1);
         if (i == 6) chk("held_press_early", key_press, 2'b00);
         if (i == 7) chk("held_press", key_press, 2'b11);
         if (i == 8) begin
            chk("held_press_end", key_press, 2'b00);
            chk("held_level", key_level, 2'b11);
         end
      end
      for (int t = 0; t < 11; t++) begin
         pc = '{0, 0};
         rc = '{0, 0};
         first = 0;
         pr = 4'b0000;
         for (int n = 1; n <= tbl[t].n; n++) begin
            step(tbl[t].kn, 1'b1);
            for (int k = 0; k < 2; k++) begin
               pc[k] += int'(key_press[k]);
               rc[k] += int'(key_release[k]);
            end
            if (first == 0 && (key_press | key_release) != 2'b00) begin
               first = n;
               pr = {key_press, key_release};
            end
         end
         chk($sformatf("seg%0d_at", t), first, tbl[t].at);
         chk($sformatf("seg%0d_pulses", t), pr, tbl[t].pr);
         chk($sformatf("seg%0d_level", t), key_level, tbl[t].lvl);
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("seg%0d_press%0d", t, k), pc[k], int'(tbl[t].pm[k]));
            chk($sformatf("seg%0d_rel%0d", t, k), rc[k], int'(tbl[t].rm[k]));
         end
      end
      bp = 0;
      lv = 0;
      for (int i = 0; i < 50; i++) begin
         step((i % 2) != 0 ? 2'b11 : 2'b10, 1'b1);
         bp += $countones({key_press, key_release});
         lv += int'(key_level[KEY_HIT]);
      end
      chk("bounce_events", bp, 0);
      chk("bounce_level", lv, 0);
      for (int i = 0; i < 10; i++) step(2'b11, 1'b1);
      bp = 0;
      for (int i = 0; i < 5; i++) begin
         step(2'b10, 1'b1);
         bp += int'(key_press[KEY_HIT]);
      end
      step(2'b10, 1'b0);
      chk("midrst_cleared", {key_level, key_press, key_release}, 6'd0);
      step(2'b10, 1'b0);
      step(2'b11, 1'b0);
      for (int i = 0; i < 15; i++) begin
         step(2'b11, 1'b1);
         bp += int'(key_press[KEY_HIT]);
      end
      chk("midrst_press", bp, 0);
      chk("midrst_level", key_level, 2'b00);
      left = 0;
      kn = 2'b11;
      for (int i = 0; i < 1500; i++) begin
         if (left == 0) begin
            kn = 2'($urandom_range(0, 3));
            left = $urandom_range(1, 12);
         end
         if ($urandom_range(0, 59) == 0) begin
            step(kn, 1'b0);
            step(kn, 1'b0);
         end else begin
            step(kn, 1'b1);
         end
         left--;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/key_conditioner.md
# key_conditioner

Front-end input block for the blackjack game: receives the raw, asynchronous, active-low pushbuttons (hit on KEY[0], stand on KEY[1]) and turns them into clean, synchronous, active-high events for the game controller inside `blackjack_top`. Each key is synchronized, debounced by a per-key state machine, and reported as a steady pressed level plus one-cycle press and release pulses. The block sits between the board pins and the game FSM, so the FSM never sees bounce or metastability.

## Interface
- `N_KEYS`, default 2: number of conditioned keys; bit 0 is hit, bit 1 is stand.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a level change. Simulation uses 4; board builds use 500000 (10 ms at 50 MHz). Legal range is 1 or more.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: counter width. Derived; never overridden.
- `CLOCK_50`, input, 1 bit: system clock, 50 MHz, rising edge.
- `resetn`, input, 1 bit: asynchronous, active-low reset, driven from KEY[2]. One clock; reset is asynchronous and active-low.
- `key_n`, input, `N_KEYS` bits: raw pushbuttons, active-low, asynchronous, may bounce.
- `key_level`, output, `N_KEYS` bits: debounced state, 1 = held.
- `key_press`, output, `N_KEYS` bits: one-cycle pulse when a press is accepted.
- `key_release`, output, `N_KEYS` bits: one-cycle pulse when a release is accepted.

## Operation
- Per key, a 2-flop synchronizer on `key_n`. The synchronizer output is `s`, inverted to active-high (`s` = 1 means pressed).
- Per-key FSM with 4 states:
  - RELEASED: if `s`=1, go to PRESS_WAIT and set cnt to 1. Otherwise stay, with cnt at 0.
  - PRESS_WAIT: if `s`=0, go to RELEASED and clear cnt (the bounce is rejected). If `s`=1 and cnt = `DEBOUNCE_CYCLES`, go to PRESSED. Otherwise increment cnt.
  - PRESSED: mirrors RELEASED with the polarity inverted; leave on `s`=0 to RELEASE_WAIT with cnt set to 1.
  - RELEASE_WAIT: `s`=1 returns to PRESSED with cnt cleared. At cnt = `DEBOUNCE_CYCLES` with `s`=0, go to RELEASED.
- Entry into PRESSED from PRESS_WAIT: `key_level` goes to 1 and `key_press` pulses for exactly one cycle.
- Entry into RELEASED from RELEASE_WAIT: `key_level` goes to 0 and `key_release` pulses for exactly one cycle.
- All outputs are registered; there is no combinational path from `key_n` to any output.
- Keys are fully independent. Simultaneous hit and stand presses produce both pulses in the same cycle. Arbitration belongs to the game FSM, not this block.
- cnt saturates by construction: it never exceeds `DEBOUNCE_CYCLES` and never wraps.

## Timing
- Reset values:
  - `key_level`, `key_press`, `key_release`: all 0.
  - Synchronizer flops: 1 (released).
  - FSM state: RELEASED; cnt = 0.
- Press latency: `key_n` falls and is first captured at edge E0. `key_press` and `key_level` are high after edge E(`DEBOUNCE_CYCLES`+2). With the default of 4, they are high after E6.
- `key_press` deasserts after the following edge. `key_level` stays high until the release is accepted.
- Release latency is symmetric: `DEBOUNCE_CYCLES`+2 edges.
- Minimum accepted pulse width: `DEBOUNCE_CYCLES`+1 consecutive stable synchronized samples. Anything shorter produces no event.
- Reset mid-operation clears everything immediately, including an in-flight PRESS_WAIT. No pulse is emitted on reset entry or exit.
- A key held through reset deassertion is reported as a fresh press after the normal latency.
- Back-to-back presses need at least 2×(`DEBOUNCE_CYCLES`+1) cycles per press/release cycle.

## Structure
- Shared package `bj_pkg` holds:
  - State encoding localparams: RELEASED=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3.
  - `DEBOUNCE_SIM`=4 and `DEBOUNCE_BOARD`=500000.
  - Key index constants: `KEY_HIT`=0, `KEY_STAND`=1.
- Sub-module `key_debounce` contains one synchronizer, one FSM, one counter and one set of output registers. It is instantiated `N_KEYS` times in a generate loop.

## Test plan
- Reset: hold `resetn`=0 with `key_n`=2'b00. Required: all outputs 0. Release reset with keys held: `key_press`=2'b11 for one cycle after edge 6, then `key_level`=2'b11.
- Clean press: `key_n[0]` goes 1→0 and is held for 20 cycles, then returns to 1. Required: exactly one `key_press[0]` pulse (after E6) and exactly one `key_release[0]` pulse, 6 edges after the release is captured. `key_level[0]` is high in between.
- Bounce rejection: `key_n[0]` toggles every cycle for 50 cycles, matching the existing top-level bench stimulus. Required: zero pulses, and `key_level[0]` stays 0.
- Near-threshold glitches: a low pulse of 4 synchronized cycles gives no event; a low pulse of 5 cycles gives exactly one press. Both use `DEBOUNCE_CYCLES`=4.
- Simultaneous keys: `key_n` goes 2'b11→2'b00 on the same edge. Required: `key_press`=2'b11 in the same single cycle.
- Reset mid-debounce: assert `resetn`=0 three cycles into PRESS_WAIT, then release with the key up. Required: no `key_press` at any time, and `key_level`=0.
